// File: rtl/dmem_dma.sv
// dmem_dma: word-copy DMA engine on the data-memory port.
// The engine copies len 32-bit words from src to dst in ascending address order.
// It takes the memory port from the core through a req/gnt handshake.
//
// Handshake: mem_req is high in RD and WR. A memory cycle happens only in a
// cycle where mem_req and mem_gnt are both high; a read is captured at that
// edge, and mem_we is raised only in that cycle. When mem_gnt is low the engine
// keeps its state and its data.
//
// Optional feature, enabled with the macro DMEM_DMA_FILL_EN: fill mode. It adds
// the fill and pattern inputs, and writes the pattern to len successive words
// at dst without reading.
module dmem_dma #(
  parameter int LEN_W  = 16,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [LEN_W-1:0]  len,
`ifdef DMEM_DMA_FILL_EN
  input  logic              fill,
  input  logic [31:0]       pattern,
`endif
  output logic              busy,
  output logic              done,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_a,
  output logic [31:0]       mem_wd,
  input  logic [31:0]       mem_rd
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] src_ptr_q, src_ptr_d;
  logic [ADDR_W-1:0] dst_ptr_q, dst_ptr_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       data_buf_q, data_buf_d;
  logic              fill_mode;

`ifdef DMEM_DMA_FILL_EN
  logic fill_q, fill_d;

  // Fill-mode flag, latched together with the rest of the job.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fill_q <= 1'b0;
    else        fill_q <= fill_d;
  end

  assign fill_mode = fill_q;
`else
  assign fill_mode = 1'b0;
`endif

  // State and job registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      src_ptr_q  <= '0;
      dst_ptr_q  <= '0;
      cnt_q      <= '0;
      data_buf_q <= '0;
    end else begin
      state_q    <= state_d;
      src_ptr_q  <= src_ptr_d;
      dst_ptr_q  <= dst_ptr_d;
      cnt_q      <= cnt_d;
      data_buf_q <= data_buf_d;
    end
  end

  // Next state: latch the job in IDLE, step pointers only on granted writes.
  always_comb begin
    state_d    = state_q;
    src_ptr_d  = src_ptr_q;
    dst_ptr_d  = dst_ptr_q;
    cnt_d      = cnt_q;
    data_buf_d = data_buf_q;
`ifdef DMEM_DMA_FILL_EN
    fill_d     = fill_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len == '0) begin
            state_d = S_DONE;
          end else begin
            src_ptr_d = {src[ADDR_W-1:2], 2'b00};
            dst_ptr_d = {dst[ADDR_W-1:2], 2'b00};
            cnt_d     = len;
            state_d   = S_RD;
`ifdef DMEM_DMA_FILL_EN
            fill_d = fill;
            if (fill) begin
              // In fill mode the pattern is held in the data buffer and RD is skipped.
              data_buf_d = pattern;
              state_d    = S_WR;
            end
`endif
          end
        end
      end
      S_RD: begin
        if (mem_gnt) begin
          data_buf_d = mem_rd;
          state_d    = S_WR;
        end
      end
      S_WR: begin
        if (mem_gnt) begin
          src_ptr_d = src_ptr_q + ADDR_W'(4);
          dst_ptr_d = dst_ptr_q + ADDR_W'(4);
          cnt_d     = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) state_d = S_DONE;
          else if (fill_mode)     state_d = S_WR;
          else                    state_d = S_RD;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Port outputs decoded from the state; everything is zero outside RD/WR.
  always_comb begin
    busy    = (state_q != S_IDLE);
    done    = 1'b0;
    mem_req = 1'b0;
    mem_we  = 1'b0;
    mem_a   = '0;
    mem_wd  = '0;
    case (state_q)
      S_RD: begin
        mem_req = 1'b1;
        mem_a   = src_ptr_q;
      end
      S_WR: begin
        mem_req = 1'b1;
        mem_a   = dst_ptr_q;
        mem_wd  = data_buf_q;
        mem_we  = mem_gnt;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
        done = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_dmem_dma.sv
// tb_dmem_dma: directed checks for dmem_dma with a 64-word memory model.
// Build with DMEM_DMA_FILL_EN defined to exercise fill mode as well.
module tb_dmem_dma;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] src;
  logic [31:0] dst;
  logic [15:0] len;
  logic        busy;
  logic        done;
  logic        mem_req;
  logic        mem_gnt;
  logic        mem_we;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;
`ifdef DMEM_DMA_FILL_EN
  logic        fill;
  logic [31:0] pattern;
`endif

  int n_checks;
  int n_fail;

  logic [31:0] mem [0:63];
  logic [31:0] wr_a_q[$];
  logic [31:0] wr_d_q[$];
  logic [31:0] rd_a_q[$];

  dmem_dma #(.LEN_W(16), .ADDR_W(32)) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .src     (src),
    .dst     (dst),
    .len     (len),
`ifdef DMEM_DMA_FILL_EN
    .fill    (fill),
    .pattern (pattern),
`endif
    .busy    (busy),
    .done    (done),
    .mem_req (mem_req),
    .mem_gnt (mem_gnt),
    .mem_we  (mem_we),
    .mem_a   (mem_a),
    .mem_wd  (mem_wd),
    .mem_rd  (mem_rd)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: combinational read, write at the rising edge, plus access logs.
  assign mem_rd = mem[mem_a[7:2]];
  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_a[7:2]] <= mem_wd;
      wr_a_q.push_back(mem_a);
      wr_d_q.push_back(mem_wd);
    end
    if (mem_req && mem_gnt && !mem_we) rd_a_q.push_back(mem_a);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload();
    for (int i = 0; i < 64; i++) mem[i] = 32'hBAD0_0000 | 32'(i);
    mem[0] = 32'h11;
    mem[1] = 32'h22;
    mem[2] = 32'h33;
    mem[3] = 32'h44;
    wr_a_q.delete();
    wr_d_q.delete();
    rd_a_q.delete();
  endtask

  // Runs one job from the start pulse. Cycle k is the k-th edge after the
  // start edge. Optional grant stall, busy-time start pulse and reset abort.
  task automatic xfer(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                      input logic f, input int stall_at, input int stall_n,
                      input logic [31:0] stall_wd, input int restart_at, input int rst_at,
                      output int done_cyc, output int busy_cyc);
    done_cyc = 0;
    busy_cyc = 0;
    src   = s;
    dst   = d;
    len   = n;
`ifdef DMEM_DMA_FILL_EN
    fill    = f;
    pattern = 32'hDEAD_BEEF;
`else
    if (f) $display("fill requested without DMEM_DMA_FILL_EN");
`endif
    mem_gnt = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      mem_gnt = !(cyc >= stall_at && cyc < stall_at + stall_n);
      if (cyc == restart_at) begin
        start = 1'b1;
        src   = 32'h0000_0020;
        dst   = 32'h0000_0060;
        len   = 16'd5;
      end
      #1;
      if (!mem_gnt) begin
        check("stall_we", {31'b0, mem_we}, 32'h0);
        check("stall_wd", mem_wd, stall_wd);
      end
      if (cyc == rst_at) begin
        check("pre_rst_we", {31'b0, mem_we}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_req", {31'b0, mem_req}, 32'h0);
        check("rst_we", {31'b0, mem_we}, 32'h0);
        check("rst_a", mem_a, 32'h0);
        check("rst_wd", mem_wd, 32'h0);
        check("rst_done", {31'b0, done}, 32'h0);
        tick();
        rst_n = 1'b1;
        done_cyc = -1;
        break;
      end
      if (busy) busy_cyc++;
      if (done) begin
        done_cyc = cyc;
        break;
      end
      tick();
      start = 1'b0;
    end
    start   = 1'b0;
    mem_gnt = 1'b1;
    if (done_cyc == 0) check("timeout", 32'h1, 32'h0);
    if (done_cyc > 0) begin
      tick();
      check("idle_after_done", {31'b0, busy}, 32'h0);
    end
  endtask

  // Main sequence.
  initial begin
    int dc;
    int bc;
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    src      = '0;
    dst      = '0;
    len      = '0;
    mem_gnt  = 1'b1;
`ifdef DMEM_DMA_FILL_EN
    fill     = 1'b0;
    pattern  = '0;
`endif
    preload();
    repeat (2) tick();
    check("reset_busy", {31'b0, busy}, 32'h0);
    check("reset_req", {31'b0, mem_req}, 32'h0);
    check("reset_a", mem_a, 32'h0);
    rst_n = 1'b1;
    tick();

    // Basic copy of four words.
    preload();
    xfer(32'h00, 32'h40, 16'd4, 1'b0, 0, 0, 32'h0, 0, 0, dc, bc);
    check("basic_done_cyc", 32'(dc), 32'd9);
    check("basic_busy_cyc", 32'(bc), 32'd9);
    check("basic_m40", mem[16], 32'h11);
    check("basic_m44", mem[17], 32'h22);
    check("basic_m48", mem[18], 32'h33);
    check("basic_m4c", mem[19], 32'h44);
    check("basic_nwr", 32'(wr_a_q.size()), 32'd4);

    // Zero length.
    preload();
    xfer(32'h00, 32'h40, 16'd0, 1'b0, 0, 0, 32'h0, 0, 0, dc, bc);
    check("zero_done_cyc", 32'(dc), 32'd1);
    check("zero_busy_cyc", 32'(bc), 32'd1);
    check("zero_nwr", 32'(wr_a_q.size()), 32'd0);
    check("zero_nrd", 32'(rd_a_q.size()), 32'd0);

    // Grant withdrawn for three cycles in the first WR.
    preload();
    xfer(32'h00, 32'h40, 16'd2, 1'b0, 2, 3, 32'h11, 0, 0, dc, bc);
    check("stall_done_cyc", 32'(dc), 32'd8);
    check("stall_m40", mem[16], 32'h11);
    check("stall_m44", mem[17], 32'h22);
    check("stall_nwr", 32'(wr_a_q.size()), 32'd2);
    check("stall_nrd", 32'(rd_a_q.size()), 32'd2);

    // Misaligned addresses and destination wrap.
    preload();
    xfer(32'h03, 32'hFFFF_FFFE, 16'd2, 1'b0, 0, 0, 32'h0, 0, 0, dc, bc);
    check("wrap_done_cyc", 32'(dc), 32'd5);
    check("wrap_nrd", 32'(rd_a_q.size()), 32'd2);
    check("wrap_nwr", 32'(wr_a_q.size()), 32'd2);
    if (rd_a_q.size() == 2 && wr_a_q.size() == 2) begin
      check("wrap_rd0", rd_a_q[0], 32'h0000_0000);
      check("wrap_rd1", rd_a_q[1], 32'h0000_0004);
      check("wrap_wa0", wr_a_q[0], 32'hFFFF_FFFC);
      check("wrap_wa1", wr_a_q[1], 32'h0000_0000);
      check("wrap_wd0", wr_d_q[0], 32'h11);
      check("wrap_wd1", wr_d_q[1], 32'h22);
    end

    // Reset during the second WR of a four-word copy.
    preload();
    xfer(32'h00, 32'hC0, 16'd4, 1'b0, 0, 0, 32'h0, 0, 4, dc, bc);
    check("abort_nwr", 32'(wr_a_q.size()), 32'd1);
    check("abort_mc0", mem[48], 32'h11);
    check("abort_mc4", mem[49], 32'hBAD0_0031);
    tick();
    check("abort_idle", {31'b0, busy}, 32'h0);

    // Restart after reset; a start pulse while busy must be ignored.
    preload();
    xfer(32'h00, 32'hC0, 16'd4, 1'b0, 0, 0, 32'h0, 3, 0, dc, bc);
    check("restart_done_cyc", 32'(dc), 32'd9);
    check("restart_busy_cyc", 32'(bc), 32'd9);
    check("restart_mc0", mem[48], 32'h11);
    check("restart_mc4", mem[49], 32'h22);
    check("restart_mc8", mem[50], 32'h33);
    check("restart_mcc", mem[51], 32'h44);
    repeat (4) tick();
    check("restart_no_queue", {31'b0, busy}, 32'h0);
    check("restart_nwr", 32'(wr_a_q.size()), 32'd4);
    check("restart_m60", mem[24], 32'hBAD0_0018);

`ifdef DMEM_DMA_FILL_EN
    // Fill mode.
    preload();
    xfer(32'h00, 32'h80, 16'd3, 1'b1, 0, 0, 32'h0, 0, 0, dc, bc);
    check("fill_done_cyc", 32'(dc), 32'd4);
    check("fill_m80", mem[32], 32'hDEAD_BEEF);
    check("fill_m84", mem[33], 32'hDEAD_BEEF);
    check("fill_m88", mem[34], 32'hDEAD_BEEF);
    check("fill_m8c", mem[35], 32'hBAD0_0023);
    check("fill_nrd", 32'(rd_a_q.size()), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
